// File: rtl/kbd_sleep_ctrl.sv
// Keyboard inactivity controller: forwards PS/2 bytes, dims then sleeps the
// display after idle timeouts, and wakes through a byte-dropping guard window.
module kbd_sleep_ctrl #(
    parameter int unsigned IDLE_LIM  = 100000000,
    parameter int unsigned WARN_LIM  = 50000000,
    parameter int unsigned GUARD_LIM = 1000000
) (
    input  logic       clk,
    input  logic       clrn,
    input  logic       ps_data,
    input  logic [7:0] data,
    input  logic       ready,
    input  logic       overflow,
    input  logic       sleep_req,
    output logic       nextdata_n,
    output logic [7:0] key_code,
    output logic       key_valid,
    output logic       display_on,
    output logic       dim,
    output logic       sleep,
    output logic       ovf_err
);

    typedef enum logic [1:0] {
        ACTIVE,
        WARN,
        SLEEP,
        GUARD
    } state_t;

    localparam logic [31:0] IDLE_LAST  = 32'(IDLE_LIM - 1);
    localparam logic [31:0] WARN_LAST  = 32'(WARN_LIM - 1);
    localparam logic [31:0] GUARD_LAST = 32'(GUARD_LIM - 1);

    state_t      r_state;
    state_t      w_state_nxt;
    logic [31:0] r_cnt;
    logic [31:0] w_cnt_nxt;
    logic        r_pop;
    logic        w_activity;
    logic        w_pop_now;
    logic        w_forward;

    assign w_activity = ~ps_data | ready;
    // A pop can only start when the previous pop phase has completed.
    assign w_pop_now  = ready & ~r_pop;
    assign w_forward  = w_pop_now & ((r_state == ACTIVE) | (r_state == WARN));

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            ACTIVE: begin
                if (sleep_req)              w_state_nxt = SLEEP;
                else if (w_activity)        w_cnt_nxt   = '0;
                else if (r_cnt == IDLE_LAST) w_state_nxt = WARN;
                else                        w_cnt_nxt   = r_cnt + 32'd1;
            end
            WARN: begin
                if (sleep_req)              w_state_nxt = SLEEP;
                else if (w_activity)        w_state_nxt = ACTIVE;
                else if (r_cnt == WARN_LAST) w_state_nxt = SLEEP;
                else                        w_cnt_nxt   = r_cnt + 32'd1;
            end
            SLEEP: begin
                w_cnt_nxt = '0;
                if (w_pop_now) w_state_nxt = GUARD;
            end
            GUARD: begin
                if (r_cnt == GUARD_LAST) w_state_nxt = ACTIVE;
                else                     w_cnt_nxt   = r_cnt + 32'd1;
            end
            default: w_state_nxt = ACTIVE;
        endcase
        if (w_state_nxt != r_state) w_cnt_nxt = '0;
    end

    always_ff @(posedge clk) begin
        if (!clrn) begin
            r_state    <= ACTIVE;
            r_cnt      <= '0;
            r_pop      <= 1'b0;
            nextdata_n <= 1'b1;
            key_valid  <= 1'b0;
            key_code   <= '0;
            display_on <= 1'b1;
            dim        <= 1'b0;
            sleep      <= 1'b0;
            ovf_err    <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_cnt      <= w_cnt_nxt;
            r_pop      <= w_pop_now;
            nextdata_n <= ~w_pop_now;
            key_valid  <= w_forward;
            if (w_forward) key_code <= data;
            display_on <= (w_state_nxt != SLEEP);
            dim        <= (w_state_nxt == WARN);
            sleep      <= (w_state_nxt == SLEEP);
            if (overflow) ovf_err <= 1'b1;
        end
    end

endmodule

// File: doc/kbd_sleep_ctrl.md
KBD_SLEEP_CTRL -- requirements
Module: kbd_sleep_ctrl

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-low reset; no other clocks or asynchronous inputs are sampled except as listed below.
REQ-002 The block SHALL have these parameters:
- IDLE_LIM, 100000000: idle cycles in ACTIVE before WARN.
- WARN_LIM, 50000000: idle cycles in WARN before SLEEP.
- GUARD_LIM, 1000000: cycles spent in GUARD after wake.
REQ-003 The block SHALL have these ports:
- clk  in  1  system clock; all logic on its rising edge.
- clrn  in  1  synchronous active-low reset.
- ps_data  in  1  PS/2 data line, pre-synchronized; low = line activity.
- data  in  8  byte from the PS/2 receiver FIFO head.
- ready  in  1  receiver FIFO non-empty.
- overflow  in  1  receiver FIFO overflow.
- sleep_req  in  1  force-sleep request, level-sampled.
- nextdata_n  out  1  active-low one-cycle pop strobe to the receiver.
- key_code  out  8  forwarded byte.
- key_valid  out  1  one-cycle strobe qualifying key_code.
- display_on  out  1  display enable.
- dim  out  1  display dim request.
- sleep  out  1  sleep indication.
- ovf_err  out  1  sticky overflow flag.

Function
REQ-004 All outputs SHALL be registered.
REQ-005 The state machine SHALL have four states: ACTIVE, WARN, SLEEP and GUARD.
REQ-006 Output decode SHALL be:
- ACTIVE: display_on=1, dim=0, sleep=0.
- WARN: display_on=1, dim=1, sleep=0.
- SLEEP: display_on=0, dim=0, sleep=1.
- GUARD: display_on=1, dim=0, sleep=0.
REQ-007 A 32-bit counter cnt SHALL be shared by all states and SHALL be cleared on every state change.
REQ-008 Activity SHALL be defined as ps_data==0 or ready==1 in a cycle.
REQ-009 Pop handshake:
- When ready==1 and the pop phase is idle, the next edge SHALL drive nextdata_n=0 and set the pop phase.
- The following edge SHALL drive nextdata_n=1 and clear the pop phase; ready is ignored during that cycle.
- Maximum throughput is therefore one byte per 2 cycles.
REQ-010 In ACTIVE or WARN, a popped byte SHALL be forwarded with latency 1: in the same cycle nextdata_n=0, key_valid=1 and key_code=data sampled at the previous edge.
REQ-011 In SLEEP or GUARD, popped bytes SHALL be discarded: key_valid=0 and key_code holds its last value.
REQ-012 ACTIVE transitions:
- Activity clears cnt.
- Otherwise cnt increments by 1.
- When cnt==IDLE_LIM-1 with no activity, the next state SHALL be WARN.
REQ-013 WARN transitions:
- Activity SHALL return the block to ACTIVE, and the byte is forwarded.
- Otherwise cnt increments by 1; when cnt==WARN_LIM-1, the next state SHALL be SLEEP.
REQ-014 SLEEP transitions:
- cnt holds 0.
- ps_data low alone SHALL NOT wake the block.
- ready==1 SHALL pop and discard the byte and move the block to GUARD.
REQ-015 GUARD transitions:
- cnt increments every cycle regardless of activity.
- All bytes are popped and discarded.
- When cnt==GUARD_LIM-1, the next state SHALL be ACTIVE.
REQ-016 sleep_req==1 in ACTIVE or WARN SHALL force SLEEP at the next edge, and SHALL win over simultaneous activity and timeouts; a pop already in phase completes normally.
REQ-017 sleep_req SHALL be ignored in SLEEP and GUARD.
REQ-018 In WARN, activity arriving in the same cycle as the timeout SHALL win, and the next state SHALL be ACTIVE.
REQ-019 cnt SHALL never exceed the active state's limit and SHALL NOT wrap.
REQ-020 ovf_err SHALL set on overflow==1 and stay set until reset.

Reset
REQ-021 While clrn==0 at a rising edge, the block SHALL reset to:
- state=ACTIVE, cnt=0, pop phase idle.
- nextdata_n=1, key_valid=0, key_code=8'h00.
- display_on=1, dim=0, sleep=0, ovf_err=0.
REQ-022 Reset asserted mid-pop SHALL abandon the pop, leaving nextdata_n=1 from the next edge, with no key_valid.

Verification (parameters IDLE_LIM=8, WARN_LIM=4, GUARD_LIM=3)
REQ-023 Idle timeout: after reset, hold ps_data=1 and ready=0 -> dim=1 after 8 cycles; sleep=1 and display_on=0 after 4 more cycles.
REQ-024 Forwarding: in ACTIVE, present data=8'h1C and hold ready=1 for 4 cycles -> nextdata_n low and key_valid high on cycles 1 and 3 only, with key_code=8'h1C.
REQ-025 Wake: in SLEEP, pulse ps_data low with ready=0 -> still asleep; then ready=1 with data=8'hF0 -> pop, no key_valid, GUARD for 3 cycles dropping bytes, then ACTIVE.
REQ-026 Priority:
- In WARN, raise ps_data low in the timeout cycle -> ACTIVE.
- In ACTIVE, raise sleep_req together with ready=1 -> byte forwarded, then SLEEP next edge.
REQ-027 Reset: assert clrn=0 during a pop and during SLEEP -> all outputs at reset values next edge; pulse overflow once -> ovf_err=1 until clrn=0.
